// File: rtl/mem_access_unit.sv
// Load/store access unit: turns a single-cycle MemRead/MemWrite request from
// control into a valid/ready bus request followed by a response, stalling the
// datapath until the DONE cycle in which it commits.
//
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   MemRead/MemWrite  - load/store request (both set = store)
//   ByteAccess        - 1 = byte access, 0 = word access
//   ALUResult         - byte address; WriteData - store data
//   ReadData          - registered load result (0 after a store or a fault)
//   Stall             - holds PC/register writes while a transaction is pending
//   MemFault          - one-cycle pulse in DONE on misalignment or bus error
//   bus_req_*/bus_we/bus_addr/bus_wdata/bus_wstrb - request channel
//   bus_rsp_valid/bus_rsp_err/bus_rdata           - response channel
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        ByteAccess,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        MemFault,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_rsp_valid,
  input  logic        bus_rsp_err,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        byte_q, byte_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic [7:0]  rd_lane;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  // Byte lane of the returned word selected by the latched address.
  always_comb begin
    rd_lane = 8'h00;
    unique case (addr_q[1:0])
      2'd0:    rd_lane = bus_rdata[7:0];
      2'd1:    rd_lane = bus_rdata[15:8];
      2'd2:    rd_lane = bus_rdata[23:16];
      default: rd_lane = bus_rdata[31:24];
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    byte_d  = byte_q;
    rdata_d = rdata_q;
    // fault_q is only ever set for the single DONE cycle, giving a pulse.
    fault_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (MemRead || MemWrite) begin
          addr_d  = ALUResult;
          we_d    = MemWrite;
          byte_d  = ByteAccess;
          // Byte stores replicate the byte so any lane picked by wstrb is right.
          wdata_d = ByteAccess ? {4{WriteData[7:0]}} : WriteData;
          if (!ByteAccess && (ALUResult[1:0] != 2'b00)) begin
            state_d = StDone;
            fault_d = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (bus_req_ready) state_d = StResp;
      end
      StResp: begin
        if (bus_rsp_valid) begin
          state_d = StDone;
          if (bus_rsp_err) begin
            fault_d = 1'b1;
            rdata_d = '0;
          end else if (we_q) begin
            rdata_d = '0;
          end else if (byte_q) begin
            rdata_d = {24'h0, rd_lane};
          end else begin
            rdata_d = bus_rdata;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Request fields come straight from the latched transaction, so they stay
  // stable for the whole of REQ regardless of the datapath inputs.
  always_comb begin
    bus_req_valid = (state_q == StReq);
    bus_we        = we_q;
    bus_addr      = {addr_q[31:2], 2'b00};
    bus_wdata     = wdata_q;
    bus_wstrb     = 4'h0;
    if (we_q) begin
      bus_wstrb = byte_q ? (4'b0001 << addr_q[1:0]) : 4'hF;
    end
    ReadData = rdata_q;
    MemFault = fault_q;
    Stall    = (MemRead | MemWrite) & (state_q != StDone);
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit. Inputs change 1 time unit after the
// rising edge; outputs are checked a further unit later. Stall cycles are
// counted at each falling edge while a transaction is in flight.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic        ByteAccess;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        MemFault;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rsp_valid;
  logic        bus_rsp_err;
  logic [31:0] bus_rdata;

  int n_assert;
  int n_fail;
  int stall_cnt;
  logic count_en;

  mem_access_unit dut (
    .clk          (clk),
    .reset        (reset),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .ByteAccess   (ByteAccess),
    .ALUResult    (ALUResult),
    .WriteData    (WriteData),
    .ReadData     (ReadData),
    .Stall        (Stall),
    .MemFault     (MemFault),
    .bus_req_valid(bus_req_valid),
    .bus_req_ready(bus_req_ready),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_wstrb    (bus_wstrb),
    .bus_rsp_valid(bus_rsp_valid),
    .bus_rsp_err  (bus_rsp_err),
    .bus_rdata    (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (count_en && Stall) stall_cnt = stall_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    ByteAccess    = 1'b0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rsp_err   = 1'b0;
  endtask

  task automatic start_count();
    stall_cnt = 0;
    count_en  = 1'b1;
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    stall_cnt = 0;
    count_en  = 1'b0;
    reset     = 1'b0;
    ALUResult = '0;
    WriteData = '0;
    bus_rdata = '0;
    idle_inputs();
    MemRead = 1'b1;  // Stall must still follow the request during reset
    #2;
    tick();
    chk("rst_readdata", ReadData, 32'h0);
    chk("rst_memfault", {31'h0, MemFault}, 32'h0);
    chk("rst_req_valid", {31'h0, bus_req_valid}, 32'h0);
    chk("rst_we", {31'h0, bus_we}, 32'h0);
    chk("rst_wstrb", {28'h0, bus_wstrb}, 32'h0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_stall_req", {31'h0, Stall}, 32'h1);
    MemRead = 1'b0;
    #1;
    chk("rst_stall_noreq", {31'h0, Stall}, 32'h0);
    tick();
    reset = 1'b1;
    tick();

    // Word read 0x100, immediate ready/response; early rsp_valid is ignored.
    MemRead = 1'b1; ALUResult = 32'h100; bus_req_ready = 1'b1;
    bus_rsp_valid = 1'b1; bus_rdata = 32'hDEADBEEF;
    start_count();
    #1;
    chk("wr_idle_valid", {31'h0, bus_req_valid}, 32'h0);
    tick();
    chk("wr_req_valid", {31'h0, bus_req_valid}, 32'h1);
    chk("wr_req_addr", bus_addr, 32'h100);
    chk("wr_req_wstrb", {28'h0, bus_wstrb}, 32'h0);
    chk("wr_req_we", {31'h0, bus_we}, 32'h0);
    tick();
    chk("wr_resp_valid", {31'h0, bus_req_valid}, 32'h0);
    chk("wr_resp_stall", {31'h0, Stall}, 32'h1);
    tick();
    chk("wr_done_stall", {31'h0, Stall}, 32'h0);
    chk("wr_done_rdata", ReadData, 32'hDEADBEEF);
    chk("wr_done_fault", {31'h0, MemFault}, 32'h0);
    count_en = 1'b0;
    chk("wr_stall_cycles", stall_cnt, 32'd3);
    idle_inputs();
    tick();
    chk("wr_rdata_hold", ReadData, 32'hDEADBEEF);

    // Byte write 0x203; address change during REQ must not leak to the bus.
    MemWrite = 1'b1; ByteAccess = 1'b1; ALUResult = 32'h203; WriteData = 32'h12345678;
    bus_req_ready = 1'b1; bus_rsp_valid = 1'b1;
    tick();
    chk("bw_addr", bus_addr, 32'h200);
    chk("bw_wstrb", {28'h0, bus_wstrb}, 32'h8);
    chk("bw_wdata", bus_wdata, 32'h78787878);
    chk("bw_we", {31'h0, bus_we}, 32'h1);
    ALUResult = 32'hFFF; ByteAccess = 1'b0;
    #1;
    chk("bw_addr_latched", bus_addr, 32'h200);
    chk("bw_wstrb_latched", {28'h0, bus_wstrb}, 32'h8);
    tick();
    tick();
    chk("bw_done_rdata", ReadData, 32'h0);
    chk("bw_done_stall", {31'h0, Stall}, 32'h0);
    idle_inputs();
    tick();

    // Byte read 0x302 -> lane 2 of 0xAABBCCDD.
    MemRead = 1'b1; ByteAccess = 1'b1; ALUResult = 32'h302; bus_rdata = 32'hAABBCCDD;
    bus_req_ready = 1'b1; bus_rsp_valid = 1'b1;
    start_count();
    tick();
    chk("br_addr", bus_addr, 32'h300);
    chk("br_wstrb", {28'h0, bus_wstrb}, 32'h0);
    tick();
    tick();
    chk("br_rdata", ReadData, 32'h000000BB);
    count_en = 1'b0;
    chk("br_stall_cycles", stall_cnt, 32'd3);
    idle_inputs();
    tick();

    // Misaligned word read 0x101: straight to DONE, no bus request.
    MemRead = 1'b1; ALUResult = 32'h101; bus_req_ready = 1'b1; bus_rsp_valid = 1'b1;
    start_count();
    #1;
    chk("mis_idle_stall", {31'h0, Stall}, 32'h1);
    tick();
    chk("mis_done_valid", {31'h0, bus_req_valid}, 32'h0);
    chk("mis_done_fault", {31'h0, MemFault}, 32'h1);
    chk("mis_done_rdata", ReadData, 32'h0);
    chk("mis_done_stall", {31'h0, Stall}, 32'h0);
    count_en = 1'b0;
    chk("mis_stall_cycles", stall_cnt, 32'd1);
    idle_inputs();
    tick();
    chk("mis_fault_pulse", {31'h0, MemFault}, 32'h0);

    // Word write 0x400: ready low for two REQ cycles, response one cycle late.
    MemWrite = 1'b1; ALUResult = 32'h400; WriteData = 32'hCAFEF00D;
    start_count();
    tick();
    chk("dw_req1_valid", {31'h0, bus_req_valid}, 32'h1);
    chk("dw_req1_wdata", bus_wdata, 32'hCAFEF00D);
    chk("dw_req1_wstrb", {28'h0, bus_wstrb}, 32'hF);
    ALUResult = 32'h8; WriteData = 32'h0; MemRead = 1'b1;
    tick();
    chk("dw_req2_valid", {31'h0, bus_req_valid}, 32'h1);
    chk("dw_req2_addr", bus_addr, 32'h400);
    chk("dw_req2_wdata", bus_wdata, 32'hCAFEF00D);
    chk("dw_req2_we", {31'h0, bus_we}, 32'h1);
    tick();
    chk("dw_req3_valid", {31'h0, bus_req_valid}, 32'h1);
    bus_req_ready = 1'b1;
    tick();
    chk("dw_resp1_valid", {31'h0, bus_req_valid}, 32'h0);
    bus_req_ready = 1'b0;
    tick();
    chk("dw_resp2_stall", {31'h0, Stall}, 32'h1);
    bus_rsp_valid = 1'b1;
    tick();
    chk("dw_done_stall", {31'h0, Stall}, 32'h0);
    count_en = 1'b0;
    chk("dw_stall_cycles", stall_cnt, 32'd6);
    idle_inputs();
    tick();

    // Word read that returns data first, so the error case below has to clear it.
    MemRead = 1'b1; ALUResult = 32'h500; bus_rdata = 32'h0BADF00D;
    bus_req_ready = 1'b1; bus_rsp_valid = 1'b1;
    tick(); tick(); tick();
    chk("pre_rdata", ReadData, 32'h0BADF00D);
    idle_inputs();
    tick();

    // Read and write together are treated as a write.
    MemRead = 1'b1; MemWrite = 1'b1; ALUResult = 32'h504; WriteData = 32'h11223344;
    bus_req_ready = 1'b1; bus_rsp_valid = 1'b1;
    tick();
    chk("rw_we", {31'h0, bus_we}, 32'h1);
    chk("rw_wstrb", {28'h0, bus_wstrb}, 32'hF);
    tick(); tick();
    chk("rw_rdata", ReadData, 32'h0);
    idle_inputs();
    tick();

    // Bus error on a read: DONE with fault, ReadData cleared.
    MemRead = 1'b1; ALUResult = 32'h500; bus_rdata = 32'h0BADF00D;
    bus_req_ready = 1'b1; bus_rsp_valid = 1'b1;
    tick(); tick();  // capture the good read again
    tick();
    idle_inputs();
    tick();
    MemRead = 1'b1; ALUResult = 32'h600; bus_rdata = 32'h12345678;
    bus_req_ready = 1'b1;
    tick(); tick();
    bus_rsp_valid = 1'b1; bus_rsp_err = 1'b1;
    tick();
    chk("err_fault", {31'h0, MemFault}, 32'h1);
    chk("err_rdata", ReadData, 32'h0);
    chk("err_stall", {31'h0, Stall}, 32'h0);
    idle_inputs();
    tick();

    // Reset in the second REQ cycle abandons the read; a stray response later is ignored.
    MemRead = 1'b1; ALUResult = 32'h700;
    tick();
    chk("ra_req1_valid", {31'h0, bus_req_valid}, 32'h1);
    tick();
    reset = 1'b0;
    #1;
    chk("ra_valid_drop", {31'h0, bus_req_valid}, 32'h0);
    chk("ra_addr_clear", bus_addr, 32'h0);
    chk("ra_stall_rst", {31'h0, Stall}, 32'h1);
    MemRead = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    bus_rsp_valid = 1'b1; bus_rdata = 32'hFFFFFFFF;
    tick();
    bus_rsp_valid = 1'b0;
    tick();
    chk("ra_stray_rdata", ReadData, 32'h0);
    chk("ra_stray_fault", {31'h0, MemFault}, 32'h0);
    chk("ra_stray_valid", {31'h0, bus_req_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Hard stop in case the sequence above ever blocks.
  initial begin
    #20000;
    $display("FAIL timeout: observed no end of test, expected end before 20000");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "timeout");
  end

endmodule
